rd_mem_req_splitter: RTL and testbench
======================================

// Module: rd_mem_req_splitter
// PURPOSE
//  Sits directly upstream of rd_mem_noc_module. Accepts one arbitrary-length read
//  (addr, total size) from a client and issues CHUNK_BYTES-aligned sub-requests,
//  one at a time. Forwards the returned NoC data flits as one continuous stream,
//  with a single last/padbytes at the end of the whole transfer.
// PARAMETERS
//  CHUNK_BYTES   256  max sub-request bytes; power of 2, multiple of `NOC_DATA_BYTES,
//                     representable in mem_req_struct.mem_req_size
//  TOTAL_SIZE_W  32   width of the client total-size field
// PORTS
//  clk                       in   1                     clock
//  rst                       in   1                     synchronous, active-high reset
//  src_rd_req_val            in   1                     client request valid
//  src_rd_req_addr           in   ADDR_W                start byte addr (ADDR_W = width of mem_req_struct.mem_req_addr)
//  src_rd_req_size           in   TOTAL_SIZE_W          total bytes, >0
//  rd_req_src_rdy            out  1                     request accepted when val&rdy
//  rd_resp_src_val           out  1                     response flit valid
//  rd_resp_src_data          out  `NOC_DATA_WIDTH        response flit data
//  rd_resp_src_last          out  1                     final flit of whole transfer
//  rd_resp_src_padbytes      out  `NOC_PADBYTES_WIDTH    invalid tail bytes; final flit only
//  src_rd_resp_rdy           in   1                     client ready for flit
//  split_rd_mem_req_val      out  1                     sub-request valid to rd_mem_noc_module
//  split_rd_mem_req_entry    out  mem_req_struct        {mem_req_addr, mem_req_size} of sub-request
//  rd_mem_split_req_rdy      in   1                     rd_mem_noc_module request ready
//  rd_mem_split_resp_val     in   1                     flit valid from rd_mem_noc_module
//  rd_mem_split_resp_data    in   `NOC_DATA_WIDTH        flit data
//  rd_mem_split_resp_last    in   1                     last flit of current sub-request
//  rd_mem_split_resp_padbytes in  `NOC_PADBYTES_WIDTH    padbytes of current sub-request
//  split_rd_mem_resp_rdy     out  1                     ready to rd_mem_noc_module
// BEHAVIOUR
//  - FSM IDLE -> ISSUE -> DRAIN -> (ISSUE | IDLE). Reset: state IDLE, cur_addr/remaining = 0.
//    All val/rdy/last outputs 0 in reset; padbytes 0; entry output reflects reset registers (0).
//  - IDLE: rd_req_src_rdy=1; on val latch cur_addr=addr, remaining=size; go ISSUE next cycle.
//  - ISSUE: split_rd_mem_req_val=1; entry.addr=cur_addr,
//    entry.size = min(remaining, CHUNK_BYTES - cur_addr[log2(CHUNK_BYTES)-1:0]).
//    On rdy: cur_addr += chunk, remaining -= chunk (registered); go DRAIN.
//    Sub-req val is first asserted in the cycle after client acceptance.
//  - DRAIN: flits pass through combinationally:
//    rd_resp_src_val=rd_mem_split_resp_val, data pass-through,
//    split_rd_mem_resp_rdy=src_rd_resp_rdy.
//    On a handshake with rd_mem_split_resp_last=1:
//      remaining==0 -> rd_resp_src_last=1, padbytes = input padbytes; go IDLE.
//      else -> last/padbytes masked to 0; go ISSUE.
//  - Client addr must be `NOC_DATA_BYTES-aligned. Under that rule non-final chunks carry 0
//    padbytes, so the stream is contiguous. Violation or size==0: assertion error only; the
//    RTL does not handle these cases.
//  - rdy is 0 in all states except those listed above. No new client request in ISSUE/DRAIN;
//    the next request is accepted no earlier than the cycle after the final flit.
//  - Widths: cur_addr ADDR_W, wraps modulo 2^ADDR_W. remaining TOTAL_SIZE_W; chunk computed in
//    TOTAL_SIZE_W, then truncated into mem_req_size.
//  - rst mid-transfer: immediately IDLE, no further sub-requests. Stray downstream flits are
//    the integrator's concern; the whole rd path is reset together.
// STRUCTURE
//  - Shared noc_struct_pkg: mem_req_struct (existing). Add a split_state_e typedef and
//    CHUNK_BYTES default localparam.
//  - Single flat module, no sub-module. Chunk-size min() is a local function.
// TESTING (NOC_DATA_BYTES=64, CHUNK_BYTES=256; downstream = rd_mem_noc_module + DRAM model)
//  1 addr 0x1000 size 256 -> one sub-req {0x1000,256}; 4 flits; last on 4th, padbytes 0.
//  2 addr 0x10C0 size 300 -> sub-reqs {0x10C0,64},{0x1100,236}; 5 flits;
//    last only on 5th, padbytes 20.
//  3 addr 0x2000 size 1024 -> 4 sub-reqs 0x2000/0x2100/0x2200/0x2300 of 256; 16 flits
//    in addr order; single last.
//  4 src_rd_resp_rdy low 10 cycles mid-chunk -> downstream rdy low; no flit lost or duplicated;
//    data matches DRAM model.
//  5 second client req held valid during transfer -> rd_req_src_rdy=0 until final flit;
//    accepted in the following cycle.
//  6 rst asserted during DRAIN of chunk 2 of 4 -> next cycle IDLE, all vals 0, rdy=1;
//    fresh request then completes correctly.

Source files
------------

// File: rtl/noc_struct_pkg.sv
// Shared NoC read-path types: memory request entry, splitter FSM states and
// default chunking granule.
package noc_struct_pkg;

  localparam int NOC_DATA_W = 512;

  localparam int NOC_PADBYTES_W = 6;

  localparam int NOC_DATA_BYTES = NOC_DATA_W / 8;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_SIZE_W = 16;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] mem_req_addr;
    logic [MEM_SIZE_W-1:0] mem_req_size;
  } mem_req_struct;

  typedef enum logic [1:0] {
    SPLIT_IDLE  = 2'd0,
    SPLIT_ISSUE = 2'd1,
    SPLIT_DRAIN = 2'd2
  } split_state_e;

  localparam int CHUNK_BYTES_DEFAULT = 256;

endpackage

// File: rtl/rd_mem_req_splitter.sv
// Breaks one arbitrary-length client read into CHUNK_BYTES-aligned sub-requests
// and stitches the returned flits into a single stream with one final last/padbytes.
module rd_mem_req_splitter
  import noc_struct_pkg::*;
#(
  parameter int CHUNK_BYTES  = CHUNK_BYTES_DEFAULT,
  parameter int TOTAL_SIZE_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_rd_req_val,
  input  logic [MEM_ADDR_W-1:0]     src_rd_req_addr,
  input  logic [TOTAL_SIZE_W-1:0]   src_rd_req_size,
  output logic                      rd_req_src_rdy,
  output logic                      rd_resp_src_val,
  output logic [NOC_DATA_W-1:0]     rd_resp_src_data,
  output logic                      rd_resp_src_last,
  output logic [NOC_PADBYTES_W-1:0] rd_resp_src_padbytes,
  input  logic                      src_rd_resp_rdy,
  output logic                      split_rd_mem_req_val,
  output mem_req_struct             split_rd_mem_req_entry,
  input  logic                      rd_mem_split_req_rdy,
  input  logic                      rd_mem_split_resp_val,
  input  logic [NOC_DATA_W-1:0]     rd_mem_split_resp_data,
  input  logic                      rd_mem_split_resp_last,
  input  logic [NOC_PADBYTES_W-1:0] rd_mem_split_resp_padbytes,
  output logic                      split_rd_mem_resp_rdy
);

  localparam int ADDR_W  = MEM_ADDR_W;
  localparam int OFF_W   = $clog2(CHUNK_BYTES);
  localparam int ALIGN_W = $clog2(NOC_DATA_BYTES);

  split_state_e              state;
  logic [ADDR_W-1:0]         cur_addr;
  logic [TOTAL_SIZE_W-1:0]   remaining;
  logic [TOTAL_SIZE_W-1:0]   chunk;
  logic                      flit_hs;
  logic                      final_chunk;

  // Bytes left before the next chunk boundary, capped by what the client still wants.
  function automatic logic [TOTAL_SIZE_W-1:0] chunk_size(
    input logic [TOTAL_SIZE_W-1:0] rem,
    input logic [OFF_W-1:0]        off
  );
    logic [TOTAL_SIZE_W-1:0] room;
    room = TOTAL_SIZE_W'(CHUNK_BYTES) - TOTAL_SIZE_W'(off);
    return (rem < room) ? rem : room;
  endfunction

  always_comb begin
    chunk       = chunk_size(remaining, cur_addr[OFF_W-1:0]);
    flit_hs     = (state == SPLIT_DRAIN) && rd_mem_split_resp_val && src_rd_resp_rdy;
    final_chunk = (remaining == '0);
  end

  assign rd_req_src_rdy         = !rst && (state == SPLIT_IDLE);
  assign split_rd_mem_req_val   = !rst && (state == SPLIT_ISSUE);
  assign split_rd_mem_req_entry = '{mem_req_addr: cur_addr, mem_req_size: MEM_SIZE_W'(chunk)};

  // Response side is a straight pass-through; only the end-of-transfer markers are gated.
  assign rd_resp_src_val       = !rst && (state == SPLIT_DRAIN) && rd_mem_split_resp_val;
  assign rd_resp_src_data      = rd_mem_split_resp_data;
  assign split_rd_mem_resp_rdy = !rst && (state == SPLIT_DRAIN) && src_rd_resp_rdy;
  assign rd_resp_src_last      = rd_resp_src_val && rd_mem_split_resp_last && final_chunk;
  assign rd_resp_src_padbytes  = rd_resp_src_last ? rd_mem_split_resp_padbytes : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SPLIT_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        SPLIT_IDLE: begin
          if (src_rd_req_val) begin
            cur_addr  <= src_rd_req_addr;
            remaining <= src_rd_req_size;
            state     <= SPLIT_ISSUE;
          end
        end
        SPLIT_ISSUE: begin
          if (rd_mem_split_req_rdy) begin
            cur_addr  <= cur_addr + ADDR_W'(chunk);
            remaining <= remaining - chunk;
            state     <= SPLIT_DRAIN;
          end
        end
        SPLIT_DRAIN: begin
          if (flit_hs && rd_mem_split_resp_last) begin
            state <= final_chunk ? SPLIT_IDLE : SPLIT_ISSUE;
          end
        end
        default: state <= SPLIT_IDLE;
      endcase
    end
  end

  // Misaligned or empty client requests are not handled by the datapath.
  a_size_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state == SPLIT_IDLE && src_rd_req_val) |-> (src_rd_req_size != '0));
  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    (state == SPLIT_IDLE && src_rd_req_val) |-> (src_rd_req_addr[ALIGN_W-1:0] == '0));

endmodule

// File: tb/tb_rd_mem_req_splitter.sv
// Directed bench for rd_mem_req_splitter: acts as client and as a simple
// downstream read engine returning address-tagged flits.
module tb_rd_mem_req_splitter;
  import noc_struct_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      src_rd_req_val;
  logic [MEM_ADDR_W-1:0]     src_rd_req_addr;
  logic [31:0]               src_rd_req_size;
  logic                      rd_req_src_rdy;
  logic                      rd_resp_src_val;
  logic [NOC_DATA_W-1:0]     rd_resp_src_data;
  logic                      rd_resp_src_last;
  logic [NOC_PADBYTES_W-1:0] rd_resp_src_padbytes;
  logic                      src_rd_resp_rdy;
  logic                      split_rd_mem_req_val;
  mem_req_struct             split_rd_mem_req_entry;
  logic                      rd_mem_split_req_rdy;
  logic                      rd_mem_split_resp_val;
  logic [NOC_DATA_W-1:0]     rd_mem_split_resp_data;
  logic                      rd_mem_split_resp_last;
  logic [NOC_PADBYTES_W-1:0] rd_mem_split_resp_padbytes;
  logic                      split_rd_mem_resp_rdy;

  int checks = 0;
  int errors = 0;

  logic [31:0] esub_addr [4];
  int          esub_size [4];

  int          ds_left;
  logic [31:0] ds_addr;
  int          ds_pad;

  rd_mem_req_splitter #(.CHUNK_BYTES(256), .TOTAL_SIZE_W(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .src_rd_req_val             (src_rd_req_val),
    .src_rd_req_addr            (src_rd_req_addr),
    .src_rd_req_size            (src_rd_req_size),
    .rd_req_src_rdy             (rd_req_src_rdy),
    .rd_resp_src_val            (rd_resp_src_val),
    .rd_resp_src_data           (rd_resp_src_data),
    .rd_resp_src_last           (rd_resp_src_last),
    .rd_resp_src_padbytes       (rd_resp_src_padbytes),
    .src_rd_resp_rdy            (src_rd_resp_rdy),
    .split_rd_mem_req_val       (split_rd_mem_req_val),
    .split_rd_mem_req_entry     (split_rd_mem_req_entry),
    .rd_mem_split_req_rdy       (rd_mem_split_req_rdy),
    .rd_mem_split_resp_val      (rd_mem_split_resp_val),
    .rd_mem_split_resp_data     (rd_mem_split_resp_data),
    .rd_mem_split_resp_last     (rd_mem_split_resp_last),
    .rd_mem_split_resp_padbytes (rd_mem_split_resp_padbytes),
    .split_rd_mem_resp_rdy      (split_rd_mem_resp_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [NOC_DATA_W-1:0] pat(input logic [31:0] a);
    return {16{a ^ 32'h5A00_0000}};
  endfunction

  task automatic check(input string tag, input logic [NOC_DATA_W-1:0] obs,
                       input logic [NOC_DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One client transfer. Starts and ends just after a falling edge.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] size,
                      input int nsub, input int nflit, input int pad,
                      input int stall_at, input int stall_len, input int rst_at,
                      input bit hold, input logic [31:0] hold_addr, input logic [31:0] hold_size);
    int sub, got, cyc, stall_cnt, sz;
    src_rd_req_val  = 1'b1;
    src_rd_req_addr = addr;
    src_rd_req_size = size;
    #1;
    check("req_rdy", rd_req_src_rdy, 1);
    @(posedge clk); @(negedge clk);
    src_rd_req_val = hold;
    if (hold) begin
      src_rd_req_addr = hold_addr;
      src_rd_req_size = hold_size;
    end
    sub = 0; got = 0; cyc = 0; stall_cnt = 0; ds_left = 0;
    while (got < nflit && cyc < 400) begin
      if (rst_at >= 0 && got == rst_at) begin
        rst = 1'b1;
        rd_mem_split_resp_val = 1'b0;
        src_rd_req_val = 1'b0;
        #1;
        check("rst_in_rdy", rd_req_src_rdy, 0);
        check("rst_in_subval", split_rd_mem_req_val, 0);
        check("rst_in_respval", rd_resp_src_val, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_rdy", rd_req_src_rdy, 1);
        check("rst_out_subval", split_rd_mem_req_val, 0);
        check("rst_out_respval", rd_resp_src_val, 0);
        check("rst_out_entry", split_rd_mem_req_entry, 0);
        ds_left = 0;
        return;
      end
      if (stall_at >= 0 && got == stall_at && stall_cnt < stall_len) begin
        src_rd_resp_rdy = 1'b0;
        stall_cnt++;
      end else begin
        src_rd_resp_rdy = 1'b1;
      end
      rd_mem_split_req_rdy = 1'b1;
      if (ds_left > 0) begin
        rd_mem_split_resp_val      = 1'b1;
        rd_mem_split_resp_data     = pat(ds_addr);
        rd_mem_split_resp_last     = (ds_left == 1);
        rd_mem_split_resp_padbytes = (ds_left == 1) ? NOC_PADBYTES_W'(ds_pad) : '0;
      end else begin
        rd_mem_split_resp_val      = 1'b0;
        rd_mem_split_resp_data     = '0;
        rd_mem_split_resp_last     = 1'b0;
        rd_mem_split_resp_padbytes = '0;
      end
      #1;
      if (hold) check("hold_rdy", rd_req_src_rdy, 0);
      if (split_rd_mem_req_val) begin
        if (sub < nsub) begin
          check("sub_addr", split_rd_mem_req_entry.mem_req_addr, esub_addr[sub]);
          check("sub_size", split_rd_mem_req_entry.mem_req_size, esub_size[sub]);
        end else begin
          check("sub_extra", sub, nsub - 1);
        end
        sz      = int'(split_rd_mem_req_entry.mem_req_size);
        ds_addr = split_rd_mem_req_entry.mem_req_addr;
        ds_left = (sz + 63) / 64;
        ds_pad  = ds_left * 64 - sz;
        sub++;
      end else if (rd_mem_split_resp_val) begin
        check("resp_val", rd_resp_src_val, 1);
        check("resp_rdy", split_rd_mem_resp_rdy, src_rd_resp_rdy);
        if (src_rd_resp_rdy) begin
          check("data", rd_resp_src_data, pat(addr + 32'(64 * got)));
          check("last", rd_resp_src_last, (got == nflit - 1));
          check("padbytes", rd_resp_src_padbytes, (got == nflit - 1) ? pad : 0);
          ds_addr += 32'd64;
          ds_left--;
          got++;
        end
      end else begin
        check("gap_resp_val", rd_resp_src_val, 0);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (got < nflit) check("timeout_flits", got, nflit);
    rd_mem_split_resp_val = 1'b0;
    src_rd_resp_rdy = 1'b1;
    #1;
    check("nsub", sub, nsub);
    check("done_rdy", rd_req_src_rdy, 1);
    check("done_subval", split_rd_mem_req_val, 0);
  endtask

  initial begin
    rst = 1'b1;
    src_rd_req_val = 1'b0; src_rd_req_addr = '0; src_rd_req_size = '0;
    src_rd_resp_rdy = 1'b1; rd_mem_split_req_rdy = 1'b0;
    rd_mem_split_resp_val = 1'b0; rd_mem_split_resp_data = '0;
    rd_mem_split_resp_last = 1'b0; rd_mem_split_resp_padbytes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", rd_req_src_rdy, 0);
    check("reset_subval", split_rd_mem_req_val, 0);
    check("reset_respval", rd_resp_src_val, 0);
    check("reset_last", rd_resp_src_last, 0);
    check("reset_pad", rd_resp_src_padbytes, 0);
    check("reset_entry", split_rd_mem_req_entry, 0);
    rst = 1'b0;
    #1;
    check("post_reset_rdy", rd_req_src_rdy, 1);
    @(negedge clk);

    // single full chunk
    esub_addr = '{32'h1000, 32'h0, 32'h0, 32'h0};
    esub_size = '{256, 0, 0, 0};
    xfer(32'h1000, 300 - 44, 1, 4, 0, -1, 0, -1, 1'b0, 0, 0);

    // unaligned start: short first chunk, padded tail
    esub_addr = '{32'h10C0, 32'h1100, 32'h0, 32'h0};
    esub_size = '{64, 236, 0, 0};
    xfer(32'h10C0, 300, 2, 5, 20, -1, 0, -1, 1'b0, 0, 0);

    // four full chunks
    esub_addr = '{32'h2000, 32'h2100, 32'h2200, 32'h2300};
    esub_size = '{256, 256, 256, 256};
    xfer(32'h2000, 1024, 4, 16, 0, -1, 0, -1, 1'b0, 0, 0);

    // client backpressure mid-chunk
    esub_addr = '{32'h3000, 32'h3100, 32'h0, 32'h0};
    esub_size = '{256, 256, 0, 0};
    xfer(32'h3000, 512, 2, 8, 0, 2, 10, -1, 1'b0, 0, 0);

    // second request held valid throughout, then accepted straight after
    esub_addr = '{32'h6000, 32'h0, 32'h0, 32'h0};
    esub_size = '{128, 0, 0, 0};
    xfer(32'h6000, 128, 1, 2, 0, -1, 0, -1, 1'b1, 32'h7080, 200);
    esub_addr = '{32'h7080, 32'h7100, 32'h0, 32'h0};
    esub_size = '{128, 72, 0, 0};
    xfer(32'h7080, 200, 2, 4, 56, -1, 0, -1, 1'b0, 0, 0);

    // reset during second chunk, then a fresh request
    esub_addr = '{32'h4000, 32'h4100, 32'h4200, 32'h4300};
    esub_size = '{256, 256, 256, 256};
    xfer(32'h4000, 1024, 4, 16, 0, -1, 0, 5, 1'b0, 0, 0);
    @(negedge clk);
    esub_addr = '{32'h5040, 32'h0, 32'h0, 32'h0};
    esub_size = '{100, 0, 0, 0};
    xfer(32'h5040, 100, 1, 2, 28, -1, 0, -1, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
